// File: rtl/seg_scan.sv
// Four-digit multiplexed display scanner with a penalty-flash / done status glyph on digit 3.
// an/seg/alarm/done are registered; segment inputs see two cycles of latency, and there is no backpressure.
module seg_scan #(
   parameter int REFRESH_DIV = 100000,
   parameter int FLASH_LEN   = 500
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [6:0] seg_a,
   input  logic [6:0] seg_b,
   input  logic [6:0] seg_c,
   input  logic       trigger_a,
   input  logic       trigger_b,
   input  logic       trigger_c,
   input  logic       stopper_a,
   input  logic       stopper_b,
   input  logic       stopper_c,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       alarm,
   output logic       done
);

   localparam int PW = $clog2(REFRESH_DIV);
   localparam int FW = (FLASH_LEN > 1) ? $clog2(FLASH_LEN) : 1;
   localparam logic [PW-1:0] PLAST = PW'(REFRESH_DIV - 1);
   localparam logic [FW-1:0] FLAST = FW'(FLASH_LEN - 1);

   typedef enum logic [1:0] {IDLE, FLASH, DONE} state_t;

   state_t        state, state_nxt;
   logic [FW-1:0] fcnt, fcnt_nxt;
   logic [PW-1:0] pcnt;
   logic [1:0]    idx;
   logic [6:0]    ra, rb, rc;
   logic [6:0]    glyph;
   logic          tick, trig, trig_q, pen, allstop;

   assign tick    = (pcnt == PLAST);
   assign trig    = trigger_a | trigger_b | trigger_c;
   assign pen     = trig & ~trig_q;
   assign allstop = stopper_a & stopper_b & stopper_c;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         fcnt  <= '0;
      end else begin
         state <= state_nxt;
         fcnt  <= fcnt_nxt;
      end
   end

   // Full stoppers win over everything; a penalty restarts the flash window.
   always_comb begin
      state_nxt = state;
      fcnt_nxt  = fcnt;
      if (allstop) begin
         state_nxt = DONE;
         fcnt_nxt  = '0;
      end else begin
         case (state)
            IDLE: begin
               if (pen) begin
                  state_nxt = FLASH;
                  fcnt_nxt  = '0;
               end
            end
            FLASH: begin
               if (pen) begin
                  fcnt_nxt = '0;
               end else if (tick) begin
                  if (fcnt == FLAST) begin
                     state_nxt = IDLE;
                     fcnt_nxt  = '0;
                  end else begin
                     fcnt_nxt = fcnt + FW'(1);
                  end
               end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      glyph = 7'b1111111;
      case (state)
         FLASH:   glyph = fcnt[0] ? 7'b1111111 : 7'b0111111;
         DONE:    glyph = 7'b0001110;
         default: glyph = 7'b1111111;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pcnt   <= '0;
         idx    <= 2'd0;
         ra     <= 7'b1111111;
         rb     <= 7'b1111111;
         rc     <= 7'b1111111;
         trig_q <= 1'b0;
         an     <= 4'b1111;
         seg    <= 7'b1111111;
         alarm  <= 1'b0;
         done   <= 1'b0;
      end else begin
         pcnt   <= tick ? '0 : pcnt + PW'(1);
         if (tick) idx <= idx + 2'd1;
         ra     <= seg_a;
         rb     <= seg_b;
         rc     <= seg_c;
         trig_q <= trig;
         an     <= ~(4'b0001 << idx);
         case (idx)
            2'd0:    seg <= ra;
            2'd1:    seg <= rb;
            2'd2:    seg <= rc;
            default: seg <= glyph;
         endcase
         alarm  <= (state_nxt == FLASH);
         done   <= (state_nxt == DONE);
      end
   end

endmodule

// File: tb/tb_seg_scan.sv
// Randomised scoreboard bench for seg_scan with REFRESH_DIV=4, FLASH_LEN=3.
module tb_seg_scan;

   localparam int DIV = 4;
   localparam int FL  = 3;

   logic       clock, reset;
   logic [6:0] seg_a, seg_b, seg_c;
   logic       trigger_a, trigger_b, trigger_c;
   logic       stopper_a, stopper_b, stopper_c;
   logic [3:0] an;
   logic [6:0] seg;
   logic       alarm, done;

   seg_scan #(.REFRESH_DIV(DIV), .FLASH_LEN(FL)) dut (
      .clock(clock), .reset(reset),
      .seg_a(seg_a), .seg_b(seg_b), .seg_c(seg_c),
      .trigger_a(trigger_a), .trigger_b(trigger_b), .trigger_c(trigger_c),
      .stopper_a(stopper_a), .stopper_b(stopper_b), .stopper_c(stopper_c),
      .an(an), .seg(seg), .alarm(alarm), .done(done)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [3:0] an;
      logic [6:0] seg;
      logic       alarm;
      logic       done;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   errors = 0;
   int   checks = 0;

   // Reference state after the most recent edge: edge count, mode, ticks seen in flash, sampled inputs.
   int         n;
   int         m_mode;   // 0 idle, 1 flash, 2 done
   int         m_ticks;
   logic       m_prev;
   logic [6:0] m_a, m_b, m_c;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] an_of(input int i);
      case (i)
         0:       return 4'b1110;
         1:       return 4'b1101;
         2:       return 4'b1011;
         default: return 4'b0111;
      endcase
   endfunction

   task automatic model_reset();
      n = 0; m_mode = 0; m_ticks = 0; m_prev = 1'b0;
      m_a = 7'h7F; m_b = 7'h7F; m_c = 7'h7F;
   endtask

   // Apply inputs for the next edge, predict the outputs after it, then step past that edge.
   task automatic drive(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c,
                        input logic [2:0] tr, input logic [2:0] st);
      exp_t e;
      int   di;
      logic tk, tg;
      seg_a = a; seg_b = b; seg_c = c;
      {trigger_c, trigger_b, trigger_a} = tr;
      {stopper_c, stopper_b, stopper_a} = st;
      di = (n / DIV) % 4;
      e.an = an_of(di);
      case (di)
         0: e.seg = m_a;
         1: e.seg = m_b;
         2: e.seg = m_c;
         default: e.seg = (m_mode == 2) ? 7'h0E :
                          (m_mode == 1 && (m_ticks % 2) == 0) ? 7'h3F : 7'h7F;
      endcase
      tk = ((n % DIV) == DIV - 1);
      tg = |tr;
      if (&st) m_mode = 2;
      else if (m_mode == 2) m_mode = 0;
      else if (tg && !m_prev) begin m_mode = 1; m_ticks = 0; end
      else if (m_mode == 1 && tk) begin
         m_ticks++;
         if (m_ticks == FL) m_mode = 0;
      end
      e.alarm = (m_mode == 1);
      e.done  = (m_mode == 2);
      m_prev = tg; m_a = a; m_b = b; m_c = c;
      n++;
      q.push_back(e);
      @(posedge clock); #2;
   endtask

   // The newest queue entry belongs to the edge still ahead, so compare only the older one.
   always @(negedge clock) begin
      if (reset && q.size() >= 2) begin
         mon_e = q.pop_front();
         chk("an", an, mon_e.an);
         chk("seg", seg, mon_e.seg);
         chk("alarm", alarm, mon_e.alarm);
         chk("done", done, mon_e.done);
      end
   end

   initial begin
      int         acnt, rises;
      logic       last;
      logic [2:0] tr, st;
      clock = 0; reset = 1;
      seg_a = 7'h7F; seg_b = 7'h7F; seg_c = 7'h7F;
      {trigger_a, trigger_b, trigger_c} = 3'b000;
      {stopper_a, stopper_b, stopper_c} = 3'b000;
      #1 reset = 0;
      #2;
      chk("rst_an", an, 4'hF);
      chk("rst_seg", seg, 7'h7F);
      chk("rst_alarm", alarm, 0);
      chk("rst_done", done, 0);
      @(posedge clock); #2;
      reset = 1; model_reset();

      repeat (40) drive(7'h77, 7'h37, 7'h36, 3'b000, 3'b000);

      acnt = 0; rises = 0; last = 1'b0;
      for (int i = 0; i < 25; i++) begin
         drive(7'h77, 7'h37, 7'h36, (i < 5) ? 3'b010 : 3'b000, 3'b000);
         if (alarm) acnt++;
         if (alarm && !last) rises++;
         last = alarm;
      end
      chk("alarm_len_in_range", (acnt >= 9 && acnt <= 15) ? 1 : 0, 1);
      chk("alarm_rises", rises, 1);

      repeat (2) drive(7'h11, 7'h22, 7'h33, 3'b001, 3'b000);
      repeat (4) drive(7'h11, 7'h22, 7'h33, 3'b000, 3'b000);
      repeat (2) drive(7'h11, 7'h22, 7'h33, 3'b001, 3'b000);
      repeat (20) drive(7'h11, 7'h22, 7'h33, 3'b000, 3'b000);

      repeat (3) drive(7'h44, 7'h55, 7'h66, 3'b000, 3'b000);
      repeat (6) drive(7'h44, 7'h55, 7'h66, 3'b100, 3'b111);
      chk("stop_done", done, 1);
      chk("stop_alarm", alarm, 0);
      drive(7'h44, 7'h55, 7'h66, 3'b000, 3'b011);
      chk("stop_release", done, 0);
      repeat (10) drive(7'h44, 7'h55, 7'h66, 3'b000, 3'b000);

      drive(7'h12, 7'h34, 7'h56, 3'b010, 3'b000);
      repeat (3) drive(7'h12, 7'h34, 7'h56, 3'b000, 3'b000);
      #1 reset = 0;
      #1;
      chk("midrst_an", an, 4'hF);
      chk("midrst_seg", seg, 7'h7F);
      chk("midrst_alarm", alarm, 0);
      chk("midrst_done", done, 0);
      q.delete();
      repeat (2) begin @(posedge clock); #2; end
      trigger_a = 1'b1;
      reset = 1; model_reset();
      repeat (3) drive(7'h12, 7'h34, 7'h56, 3'b001, 3'b000);
      repeat (20) drive(7'h12, 7'h34, 7'h56, 3'b000, 3'b000);

      tr = 3'b000; st = 3'b000;
      for (int i = 0; i < 3000; i++) begin
         for (int b = 0; b < 3; b++) begin
            if ($urandom_range(0, 9) == 0) tr[b] = ~tr[b];
            if ($urandom_range(0, 24) == 0) st[b] = ~st[b];
         end
         drive(7'($urandom), 7'($urandom), 7'($urandom), tr, st);
      end
      @(negedge clock);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
